// File: rtl/player_motion_ctrl.sv
// Per-frame walk/scroll decision and jump/gravity FSM for the player sprite.
// Optional double jump is enabled by defining PLAYER_DOUBLE_JUMP_EN.
module player_motion_ctrl #(
  parameter logic [9:0] X_MIN     = 10'd0,
  parameter logic [9:0] SCROLL_X  = 10'd300,
  parameter logic [9:0] X_MAX     = 10'd620,
  parameter logic [9:0] GROUND_Y  = 10'd368,
  parameter logic [3:0] STEP_X    = 4'd2,
  parameter logic [4:0] JUMP_V    = 5'd12,
  parameter logic [4:0] V_MAX     = 5'd10,
  parameter logic [8:0] BG_MAX    = 9'd400,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_JUMP  = 8'h1A
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       can_up,
  input  logic       can_down,
  input  logic       can_left,
  input  logic       can_right,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [8:0] bg_step,
  output logic       airborne,
  output logic       facing_left
);

  typedef enum logic [1:0] {
    GROUND,
    RISE,
    FALL
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [8:0]  bg_q, bg_d;
  logic [4:0]  vy_q, vy_d;
  logic        face_q, face_d;
  logic        jprev_q, jprev_d;
  logic        jump_key, jump_edge;
  logic [10:0] x_fwd, x_lim;
  logic [9:0]  x_bak;
  logic [9:0]  y_up;
  logic [10:0] y_dn;

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic extra_q, extra_d;
  logic dj;
`endif

  assign jump_key  = (keycode == KEY_JUMP);
  assign jump_edge = jump_key && !jprev_q;

  // Widened sums so clamping compares never see a wrapped value
  assign x_fwd = {1'b0, x_q} + {7'd0, STEP_X};
  assign x_lim = {1'b0, X_MIN} + {7'd0, STEP_X};
  assign x_bak = x_q - {6'd0, STEP_X};
  assign y_up  = y_q - {5'd0, vy_q};
  assign y_dn  = {1'b0, y_q} + {6'd0, vy_q};

  always_comb begin
    x_d    = x_q;
    bg_d   = bg_q;
    face_d = face_q;
    if (keycode == KEY_RIGHT) begin
      face_d = 1'b0;
      if (can_right) begin
        if (x_q < SCROLL_X)
          x_d = (x_fwd > {1'b0, SCROLL_X}) ?
                SCROLL_X : x_fwd[9:0];
        else if (bg_q < BG_MAX)
          bg_d = bg_q + 9'd1;
        else
          x_d = (x_fwd > {1'b0, X_MAX}) ?
                X_MAX : x_fwd[9:0];
      end
    end else if (keycode == KEY_LEFT) begin
      face_d = 1'b1;
      if (can_left)
        x_d = ({1'b0, x_q} < x_lim) ? X_MIN : x_bak;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vy_d    = vy_q;
    jprev_d = jump_key;
    unique case (state_q)
      GROUND: begin
        if (jump_edge && can_up) begin
          state_d = RISE;
          vy_d    = JUMP_V;
        end else if (can_down && y_q < GROUND_Y) begin
          state_d = FALL;
          vy_d    = 5'd1;
        end
      end
      RISE: begin
        if (!can_up || vy_q == 5'd0) begin
          state_d = FALL;
          vy_d    = 5'd0;
        end else begin
          y_d  = (y_q < {5'd0, vy_q}) ? 10'd0 : y_up;
          vy_d = vy_q - 5'd1;
        end
      end
      FALL: begin
        if (!can_down) begin
          state_d = GROUND;
          vy_d    = 5'd0;
        end else if (y_dn >= {1'b0, GROUND_Y}) begin
          state_d = GROUND;
          y_d     = GROUND_Y;
          vy_d    = 5'd0;
        end else begin
          y_d  = y_dn[9:0];
          vy_d = (vy_q >= V_MAX) ? V_MAX : vy_q + 5'd1;
        end
      end
      default: begin
        state_d = GROUND;
        vy_d    = 5'd0;
      end
    endcase
`ifdef PLAYER_DOUBLE_JUMP_EN
    dj      = jump_edge && can_up && extra_q &&
              (state_q != GROUND);
    extra_d = extra_q;
    if (state_d == GROUND)
      extra_d = 1'b1;
    // Mid-air relaunch keeps y and restarts the rise
    if (dj) begin
      state_d = RISE;
      y_d     = y_q;
      vy_d    = JUMP_V;
      extra_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= GROUND;
      x_q     <= 10'd40;
      y_q     <= GROUND_Y;
      bg_q    <= 9'd0;
      vy_q    <= 5'd0;
      face_q  <= 1'b0;
      jprev_q <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      extra_q <= 1'b1;
`endif
    end else if (frame_tick) begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bg_q    <= bg_d;
      vy_q    <= vy_d;
      face_q  <= face_d;
      jprev_q <= jprev_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
      extra_q <= extra_d;
`endif
    end
  end

  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign bg_step     = bg_q;
  assign airborne    = (state_q != GROUND);
  assign facing_left = face_q;

endmodule
